// File: rtl/uart_rx.sv
// UART receive path: synchronizes RX_IN, oversamples each bit PRESCALE times with a
// 3-sample mid-bit majority vote, and checks start/parity/stop before strobing a byte.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state, state_n;

    logic [1:0]            rx_sync;
    logic                  rx_s;
    logic [5:0]            p_cap;
    logic                  par_en_cap;
    logic                  par_typ_cap;
    logic [5:0]            edge_cnt;
    logic [BCW-1:0]        bit_cnt;
    logic [1:0]            samp;
    logic                  bit_val;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_bad;

    logic [5:0] half;
    logic       last_edge;
    logic       vote_edge;
    logic       decide_edge;
    logic       vote;

    logic start_det;
    logic go_idle;
    logic shift_en;
    logic par_chk;
    logic verdict;

    // The synchronizer resets to the idle level so reset release never looks like a start edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) rx_sync <= 2'b11;
        else      rx_sync <= {rx_sync[0], RX_IN};
    end
    assign rx_s = rx_sync[1];

    assign half        = {1'b0, p_cap[5:1]};
    assign last_edge   = (edge_cnt == p_cap - 6'd1);
    assign vote_edge   = (edge_cnt == half + 6'd1);
    assign decide_edge = (edge_cnt == half + 6'd2);
    // Third sample is the live rx_s, so the vote is ready in the same cycle as that sample.
    assign vote = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_n;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        start_det = 1'b0;
        go_idle   = 1'b0;
        shift_en  = 1'b0;
        par_chk   = 1'b0;
        verdict   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    start_det = 1'b1;
                    state_n   = START;
                end
            end
            START: begin
                if (decide_edge && bit_val) begin
                    go_idle = 1'b1;
                    state_n = IDLE;
                end else if (last_edge) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (last_edge) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) state_n = par_en_cap ? PARITY : STOP;
                end
            end
            PARITY: begin
                par_chk = decide_edge;
                if (last_edge) state_n = STOP;
            end
            STOP: begin
                verdict = vote_edge;
                if (decide_edge) begin
                    go_idle = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_cap       <= 6'd8;
            par_en_cap  <= 1'b0;
            par_typ_cap <= 1'b0;
            edge_cnt    <= '0;
            bit_cnt     <= '0;
            samp        <= '0;
            bit_val     <= 1'b0;
            shift_reg   <= '0;
            par_bad     <= 1'b0;
            P_DATA      <= '0;
            DATA_VALID  <= 1'b0;
            PAR_ERR     <= 1'b0;
            STP_ERR     <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            if (start_det) begin
                p_cap       <= PRESCALE;
                par_en_cap  <= PAR_EN;
                par_typ_cap <= PAR_TYP;
                par_bad     <= 1'b0;
                edge_cnt    <= 6'd1;
                bit_cnt     <= '0;
            end else if (state == IDLE || go_idle) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                edge_cnt <= last_edge ? 6'd0 : edge_cnt + 6'd1;
                if (shift_en) bit_cnt <= bit_cnt + 1'b1;
            end

            if (edge_cnt == half - 6'd1) samp[0] <= rx_s;
            if (edge_cnt == half)        samp[1] <= rx_s;
            if (vote_edge)               bit_val <= vote;

            if (shift_en) shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
            if (par_chk)  par_bad   <= (bit_val != (^shift_reg ^ par_typ_cap));

            if (verdict) begin
                STP_ERR <= ~vote;
                PAR_ERR <= par_bad;
                if (vote && !par_bad) begin
                    DATA_VALID <= 1'b1;
                    P_DATA     <= shift_reg;
                end
            end
        end
    end

endmodule
